// File: rtl/mwshift_r_seq.sv
// Word-serial multi-word right shifter: streams a WORD_COUNT-word shifted operand
// one word per beat, each word produced by a double-precision polyshift_r slice.

module polyshift_r #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]         data_i,
    input  logic [WIDTH-2:0]         c_i,
    input  logic [$clog2(WIDTH)-1:0] shift_size_i,
    input  logic [1:0]               shift_type_i,
    output logic [WIDTH-1:0]         data_o
);
    localparam int SW = $clog2(WIDTH) + 1;

    logic [WIDTH-2:0]   w_upper;
    logic [2*WIDTH-2:0] w_ext;

    // Every type reduces to picking the bits shifted in above data_i
    always_comb begin
        case (shift_type_i)
            2'd0:    w_upper = '0;
            2'd1:    w_upper = {(WIDTH-1){data_i[WIDTH-1]}};
            2'd2:    w_upper = c_i;
            default: w_upper = data_i[WIDTH-2:0];
        endcase
    end

    assign w_ext = {w_upper, data_i};

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [SW-1:0] w_idx;
        assign w_idx      = SW'(gi) + {1'b0, shift_size_i};
        assign data_o[gi] = w_ext[w_idx];
    end
endmodule

module mwshift_r_seq #(
    parameter int WORD_WIDTH = 16,
    parameter int WORD_COUNT = 4
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      start_i,
    input  logic [WORD_COUNT*WORD_WIDTH-1:0]          data_i,
    input  logic [$clog2(WORD_COUNT*WORD_WIDTH)-1:0]  shift_size_i,
    input  logic [1:0]                                shift_type_i,
    input  logic [WORD_WIDTH-1:0]                     fill_i,
    output logic                                      ready_o,
    output logic                                      valid_o,
    input  logic                                      ready_i,
    output logic [WORD_WIDTH-1:0]                     word_o,
    output logic [$clog2(WORD_COUNT)-1:0]             word_idx_o,
    output logic                                      last_o
);
    localparam int W  = WORD_COUNT * WORD_WIDTH;
    localparam int SW = $clog2(W);
    localparam int BW = $clog2(WORD_WIDTH);
    localparam int IW = $clog2(WORD_COUNT);
    localparam int JW = IW + 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                r_state;
    logic [W-1:0]          r_data;
    logic [SW-1:0]         r_size;
    logic [1:0]            r_type;
    logic [WORD_WIDTH-1:0] r_fill;
    logic                  r_valid;
    logic [WORD_WIDTH-1:0] r_word;
    logic [IW-1:0]         r_idx;
    logic                  r_last;

    logic                  w_idle;
    logic [W-1:0]          w_op;
    logic [SW-1:0]         w_size;
    logic [1:0]            w_type;
    logic [WORD_WIDTH-1:0] w_fill;
    logic [W-1:0]          w_hi;
    logic [2*W-1:0]        w_src;
    logic [IW-1:0]         w_k;
    logic [IW-1:0]         w_q;
    logic [BW-1:0]         w_r;
    logic [JW-1:0]         w_j0;
    logic [JW-1:0]         w_j1;
    logic [WORD_WIDTH-1:0] w_cur;
    logic [WORD_WIDTH-2:0] w_carry;
    logic [WORD_WIDTH-1:0] w_result;

    assign w_idle = (r_state == S_IDLE);

    // While idle the live inputs feed the datapath so word 0 is ready at the accept edge
    assign w_op   = w_idle ? data_i       : r_data;
    assign w_size = w_idle ? shift_size_i : r_size;
    assign w_type = w_idle ? shift_type_i : r_type;
    assign w_fill = w_idle ? fill_i       : r_fill;
    assign w_k    = w_idle ? '0           : r_idx + 1'b1;

    assign w_q = w_size[SW-1:BW];
    assign w_r = w_size[BW-1:0];

    always_comb begin
        case (w_type)
            2'd0:    w_hi = '0;
            2'd1:    w_hi = {W{w_op[W-1]}};
            2'd2:    w_hi = {WORD_COUNT{w_fill}};
            default: w_hi = w_op;
        endcase
    end

    assign w_src   = {w_hi, w_op};
    assign w_j0    = {1'b0, w_k} + {1'b0, w_q};
    assign w_j1    = w_j0 + 1'b1;
    assign w_cur   = w_src[{w_j0, {BW{1'b0}}} +: WORD_WIDTH];
    assign w_carry = w_src[{w_j1, {BW{1'b0}}} +: (WORD_WIDTH-1)];

    polyshift_r #(
        .WIDTH(WORD_WIDTH)
    ) u_polyshift (
        .data_i      (w_cur),
        .c_i         (w_carry),
        .shift_size_i(w_r),
        .shift_type_i(2'd2),
        .data_o      (w_result)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_size  <= '0;
            r_type  <= '0;
            r_fill  <= '0;
            r_valid <= 1'b0;
            r_word  <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state <= S_RUN;
                        r_data  <= data_i;
                        r_size  <= shift_size_i;
                        r_type  <= shift_type_i;
                        r_fill  <= fill_i;
                        r_valid <= 1'b1;
                        r_word  <= w_result;
                        r_idx   <= '0;
                        r_last  <= 1'b0;
                    end
                end
                default: begin
                    if (ready_i) begin
                        if (r_last) begin
                            r_state <= S_IDLE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                        end else begin
                            r_word <= w_result;
                            r_idx  <= w_k;
                            r_last <= (w_k == IW'(WORD_COUNT-1));
                        end
                    end
                end
            endcase
        end
    end

    assign ready_o    = w_idle;
    assign valid_o    = r_valid;
    assign word_o     = r_word;
    assign word_idx_o = r_idx;
    assign last_o     = r_last;
endmodule

// File: tb/tb_mwshift_r_seq.sv
// Bench for mwshift_r_seq (8-bit words x 4): scoreboard of expected beats
// built from a 64-bit reference shift, compared as the DUT streams words out.

module tb_mwshift_r_seq;
    localparam int WW = 8;
    localparam int WC = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] data_i = '0;
    logic [4:0]  shift_size_i = '0;
    logic [1:0]  shift_type_i = '0;
    logic [7:0]  fill_i = '0;
    logic        ready_o;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [7:0]  word_o;
    logic [1:0]  word_idx_o;
    logic        last_o;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] word;
        logic [1:0] idx;
        logic       last;
    } beat_t;

    beat_t exp_q[$];

    always #5 clk_i = ~clk_i;

    mwshift_r_seq #(.WORD_WIDTH(WW), .WORD_COUNT(WC)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .data_i      (data_i),
        .shift_size_i(shift_size_i),
        .shift_type_i(shift_type_i),
        .fill_i      (fill_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .word_o      (word_o),
        .word_idx_o  (word_idx_o),
        .last_o      (last_o)
    );

    function automatic logic [31:0] model(input logic [31:0] d, input int s,
                                          input logic [1:0] t, input logic [7:0] f);
        logic [63:0] ext;
        case (t)
            2'd0:    ext = {32'h0, d};
            2'd1:    ext = {{32{d[31]}}, d};
            2'd2:    ext = {{4{f}}, d};
            default: ext = {d, d};
        endcase
        ext = ext >> s;
        return ext[31:0];
    endfunction

    // Caller is at a falling edge; accept happens at the following rising edge
    task automatic start_op(input logic [31:0] d, input int s, input logic [1:0] t,
                            input logic [7:0] f);
        logic [31:0] r;
        checks++;
        if (ready_o !== 1'b1) begin
            failures++;
            $display("FAIL start_ready got=%b required=1", ready_o);
        end
        data_i = d; shift_size_i = 5'(s); shift_type_i = t; fill_i = f;
        start_i = 1'b1;
        r = model(d, s, t, f);
        for (int k = 0; k < WC; k++)
            exp_q.push_back('{word: r[k*8 +: 8], idx: 2'(k), last: (k == WC-1)});
        $display("op type=%0d s=%0d data=%h fill=%h expect=%h", t, s, d, f, r);
        @(negedge clk_i);
        start_i = 1'b0;
        data_i = $urandom; shift_size_i = 5'($urandom);
        shift_type_i = 2'($urandom); fill_i = 8'($urandom);
    endtask

    task automatic drain(input int stall_idx, input int stall_len, input bit pulse,
                         input string name);
        int    cyc = 0;
        int    stall_left = 0;
        bit    stalled = 0;
        bit    finished = 0;
        bit    last_taken = 0;
        beat_t e;
        beat_t got;
        while (!finished && cyc < 40) begin
            cyc++;
            got = '{word: word_o, idx: word_idx_o, last: last_o};
            if (!valid_o) begin
                checks++; failures++;
                $display("FAIL %s_valid cyc=%0d got valid_o=0 required 1", name, cyc);
            end else if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL %s_extra got word=%h idx=%0d required no beat", name, word_o, word_idx_o);
                finished = 1;
            end else begin
                e = exp_q[0];
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL %s_beat got word=%h idx=%0d last=%b required word=%h idx=%0d last=%b",
                             name, got.word, got.idx, got.last, e.word, e.idx, e.last);
                end
                if (!stalled && stall_len > 0 && int'(word_idx_o) == stall_idx) begin
                    stalled = 1; stall_left = stall_len;
                end
            end
            if (stall_left > 0) begin
                ready_i = 1'b0;
                start_i = pulse && (stall_left == 2);
                data_i = 32'hDEADBEEF; shift_size_i = 5'd9; shift_type_i = 2'd3;
                stall_left--;
            end else begin
                ready_i = 1'b1;
                start_i = 1'b0;
                if (valid_o && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    last_taken = e.last;
                end
            end
            @(negedge clk_i);
            if (last_taken && !finished) begin
                checks++;
                if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_idle got valid_o=%b ready_o=%b required 0 1", name, valid_o, ready_o);
                end
                finished = 1;
            end
        end
        start_i = 1'b0;
        ready_i = 1'b1;
        if (!finished) begin
            checks++; failures++;
            $display("FAIL %s_timeout got %0d beats pending required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || word_o !== 8'h00 ||
            word_idx_o !== 2'd0 || last_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got ready=%b valid=%b word=%h idx=%0d last=%b required 1 0 00 0 0",
                     ready_o, valid_o, word_o, word_idx_o, last_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_logic();
        start_op(32'h12345678, 4, 2'd0, 8'h00);
        drain(-1, 0, 0, "logic");
    endtask

    task automatic test_arith();
        start_op(32'h80000000, 31, 2'd1, 8'h00);
        drain(-1, 0, 0, "arith_neg");
        start_op(32'h7FFFFFFF, 31, 2'd1, 8'h00);
        drain(-1, 0, 0, "arith_pos");
    endtask

    task automatic test_cyclic();
        start_op(32'h12345678, 12, 2'd3, 8'h00);
        drain(-1, 0, 0, "cyclic12");
        start_op(32'h12345678, 0, 2'd3, 8'h00);
        drain(-1, 0, 0, "cyclic0");
        start_op(32'h9ABCDEF1, 31, 2'd3, 8'h00);
        drain(-1, 0, 0, "cyclic31");
    endtask

    task automatic test_fill();
        start_op(32'h12345678, 8, 2'd2, 8'hAB);
        drain(-1, 0, 0, "fill8");
        start_op(32'hF00DCAFE, 27, 2'd2, 8'h5C);
        drain(-1, 0, 0, "fill27");
    endtask

    task automatic test_backpressure();
        start_op(32'h12345678, 4, 2'd0, 8'h00);
        drain(1, 3, 1, "stall");
    endtask

    task automatic test_reset_midrun();
        bit seen = 0;
        start_op(32'h12345678, 4, 2'd0, 8'h00);
        ready_i = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (valid_o && word_idx_o == 2'd2) seen = 1;
            else @(negedge clk_i);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL midrun_reach got idx=%0d valid=%b required idx=2 valid=1", word_idx_o, valid_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || word_o !== 8'h00 || ready_o !== 1'b1 ||
            word_idx_o !== 2'd0 || last_o !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset got valid=%b word=%h ready=%b idx=%0d last=%b required 0 00 1 0 0",
                     valid_o, word_o, ready_o, word_idx_o, last_o);
        end
        exp_q.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            checks++;
            if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
                failures++;
                $display("FAIL post_reset_idle got valid=%b ready=%b required 0 1", valid_o, ready_o);
            end
        end
        start_op(32'hCAFEF00D, 13, 2'd1, 8'h00);
        drain(-1, 0, 0, "post_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            start_op($urandom, int'($urandom_range(0, 31)), 2'($urandom), 8'($urandom));
            drain(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_logic();
        test_arith();
        test_cyclic();
        test_fill();
        test_backpressure();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mwshift_r_seq.md
# mwshift_r_seq

Word-serial multi-word right shifter that sits directly upstream of `polyshift_r` and drives it. It captures a `WORD_COUNT`-word operand and performs a logic, arithmetic, fill or cyclic right shift across the whole operand. Each cycle it presents a source word, a carry word and the bit offset to an internal `polyshift_r` instance configured for DOUBLE_PRECISION. The result streams out one word per accepted beat, least-significant word first, under valid/ready backpressure.

## Interface
- `WORD_WIDTH`, default 16: width of one word. Must be a power of two and ≥ 4.
- `WORD_COUNT`, default 4: number of words in the operand. Must be a power of two and ≥ 2.
- `clk_i` input, 1 bit: clock; all state changes on the rising edge.
- `rst_ni` input, 1 bit: reset, asynchronous, active-low.
- `start_i` input, 1 bit: request. Accepted only when `start_i && ready_o`.
- `data_i` input, `WORD_COUNT*WORD_WIDTH` bits: operand, captured on accept.
- `shift_size_i` input, `$clog2(WORD_COUNT*WORD_WIDTH)` bits: shift distance, captured on accept.
- `shift_type_i` input, 2 bits: shift type, captured on accept.
  - 0 = LOGIC
  - 1 = ARITHMETIC
  - 2 = FILL
  - 3 = CYCLIC
- `fill_i` input, `WORD_WIDTH` bits: fill word for FILL, captured on accept.
- `ready_o` output, 1 bit: block is idle and can accept `start_i`.
- `valid_o` output, 1 bit: `word_o` holds a valid result word.
- `ready_i` input, 1 bit: consumer accepts `word_o` this cycle.
- `word_o` output, `WORD_WIDTH` bits: result word.
- `word_idx_o` output, `$clog2(WORD_COUNT)` bits: index of `word_o`; 0 is the least-significant word.
- `last_o` output, 1 bit: `word_o` is word `WORD_COUNT-1`.

## Operation
- Width rules. W = `WORD_COUNT*WORD_WIDTH`, s = captured shift size.
  - q = s[msb:$clog2(WORD_WIDTH)] (word offset).
  - r = s[$clog2(WORD_WIDTH)-1:0] (bit offset).
  - No division logic is used; q and r are bit slices of s.
- Source word j, for 0 ≤ j < 2*`WORD_COUNT`:
  - j < `WORD_COUNT`: operand word j.
  - Otherwise, by type:
    - LOGIC: all zeros.
    - ARITHMETIC: every bit equals operand bit W-1.
    - FILL: captured `fill_i`.
    - CYCLIC: operand word j-`WORD_COUNT`.
- Result word k is the `polyshift_r` output with:
  - `data_i` = source word k+q
  - `c_i` = source word k+q+1, bits [WORD_WIDTH-2:0]
  - `shift_size_i` = r
  - `shift_type_i` = 2 (DOUBLE_PRECISION)
- The concatenated result equals the W-bit shift of the operand by s, filled per type. CYCLIC is a rotate.
- State machine:
  - IDLE → RUN on accept. The operand, size, type and fill are registered; word index k = 0.
  - RUN: the `word_o` register is loaded with result word k. On `valid_o && ready_i`, k increments and the next word is loaded.
  - RUN → IDLE when the beat with `last_o` is accepted.
- `start_i` while in RUN is ignored and does not disturb the captured operand.
- `ready_o` = (state == IDLE). It is combinational from the state register.
- `word_o`, `word_idx_o` and `last_o` are held stable while `valid_o && !ready_i`.
- s = 0 passes the operand unchanged. q = `WORD_COUNT-1` with r = `WORD_WIDTH-1` is the maximum shift and must be exact.

## Timing
- Reset values (asserted asynchronously, released synchronously on the next clock):
  - state = IDLE
  - `ready_o` = 1
  - `valid_o` = 0
  - `word_o` = 0
  - `word_idx_o` = 0
  - `last_o` = 0
  - all captured registers = 0
- Accept at edge T: `valid_o` = 1 with word 0 from T+1.
- Throughput: one word per cycle while `ready_i` is held high. Word `WORD_COUNT-1` is valid from T+`WORD_COUNT`.
- After the last accepted beat, `valid_o` = 0 and `ready_o` = 1 in the next cycle. This gives at least one idle cycle between operations; back-to-back accept in the last-beat cycle is not supported.
- Reset asserted mid-RUN: all outputs return to their reset values immediately. No partial word is emitted after reset is released.

## Test plan
All cases use `WORD_WIDTH`=8, `WORD_COUNT`=4, `ready_i`=1 unless stated.
- LOGIC: `data_i`=0x12345678, s=4 → words 0x67, 0x45, 0x23, 0x01. `last_o` is high on the 4th word. `ready_o` returns to 1 the cycle after.
- ARITHMETIC: `data_i`=0x80000000, s=31 → words 0xFF, 0xFF, 0xFF, 0xFF. Then `data_i`=0x7FFFFFFF, s=31 → 0x00 ×4.
- CYCLIC: `data_i`=0x12345678, s=12 → words 0x45, 0x23, 0x81, 0x67 (0x67812345). Then s=0 → 0x78, 0x56, 0x34, 0x12.
- FILL: `fill_i`=0xAB, `data_i`=0x12345678, s=8 → words 0x56, 0x34, 0x12, 0xAB.
- Backpressure and ignore: in LOGIC s=4, `ready_i` is low for 3 cycles after word 1 appears → `word_o`=0x45 and `word_idx_o`=1 are held stable. A `start_i` pulse during that stall is ignored, and the remaining words are unchanged.
- Reset mid-run: `rst_ni` is pulled low while `word_idx_o`=2 → `valid_o`=0, `word_o`=0 and `ready_o`=1 immediately. A new accept after reset produces a correct complete 4-word result.
